gray_ticket_arbiter: RTL and testbench



---
 rtl/gray_ticket_arbiter.sv | 144 ++++++++++++++
 tb/tb_gray_ticket_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ticket_arbiter.sv
// Round-robin arbiter that hands each winner a unique Gray-coded ticket from a
// shared binary counter, using a 4-phase req/gnt handshake.
module gray_ticket_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             clear,
  input  logic             hold,
  output logic [N_REQ-1:0] gnt,
  output logic [WIDTH-1:0] ticket,
  output logic             ticket_valid,
  output logic             wrap,
  output logic             busy
);

  localparam int            PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] PTR_RESET = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] bin_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    win_q;
  logic [N_REQ-1:0] gnt_q;
  logic [WIDTH-1:0] ticket_q;
  logic             ticket_valid_q;
  logic             wrap_q;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic [PW-1:0]    win_d;
  logic             found_d;
  logic             start_d;

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  // Round-robin search: first asserted request after the last winner, wrapping.
  always_comb begin
    found_d = 1'b0;
    win_d   = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found_d && req[PW'((int'(ptr_q) + i) % N_REQ)]) begin
        found_d = 1'b1;
        win_d   = PW'((int'(ptr_q) + i) % N_REQ);
      end else begin
        found_d = found_d;
      end
    end
  end

  assign bin_d   = bin_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign gray_d  = bin2gray(bin_q);
  assign start_d = found_d & ~hold;

  // Handshake FSM with registered grant, ticket and wrap outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      bin_q          <= {WIDTH{1'b0}};
      ptr_q          <= PTR_RESET;
      win_q          <= {PW{1'b0}};
      gnt_q          <= {N_REQ{1'b0}};
      ticket_q       <= {WIDTH{1'b0}};
      ticket_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else if (clear) begin
      state_q        <= IDLE;
      bin_q          <= {WIDTH{1'b0}};
      ptr_q          <= PTR_RESET;
      win_q          <= {PW{1'b0}};
      gnt_q          <= {N_REQ{1'b0}};
      ticket_q       <= {WIDTH{1'b0}};
      ticket_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_d) begin
            gnt_q          <= onehot(win_d);
            ticket_q       <= gray_d;
            ticket_valid_q <= 1'b1;
            wrap_q         <= &bin_q;
            bin_q          <= bin_d;
            ptr_q          <= win_d;
            win_q          <= win_d;
            state_q        <= GRANT;
          end else begin
            gnt_q          <= {N_REQ{1'b0}};
            ticket_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        GRANT: begin
          gnt_q          <= {N_REQ{1'b0}};
          ticket_valid_q <= 1'b0;
          wrap_q         <= 1'b0;
          state_q        <= RELEASE;
        end
        RELEASE: begin
          gnt_q          <= {N_REQ{1'b0}};
          ticket_valid_q <= 1'b0;
          wrap_q         <= 1'b0;
          // Only the winner's handshake matters here; others stay pending.
          if (!req[win_q]) begin
            state_q <= IDLE;
          end else begin
            state_q <= RELEASE;
          end
        end
        default: begin
          gnt_q          <= {N_REQ{1'b0}};
          ticket_valid_q <= 1'b0;
          wrap_q         <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign ticket       = ticket_q;
  assign ticket_valid = ticket_valid_q;
  assign wrap         = wrap_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gray_ticket_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts grants into a queue,
// a negedge monitor pops and compares whenever the arbiter presents a ticket.
module tb_gray_ticket_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [N_REQ-1:0] req     = 4'b0000;
  logic             clear   = 1'b0;
  logic             hold    = 1'b0;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] ticket;
  logic             ticket_valid;
  logic             wrap;
  logic             busy;

  gray_ticket_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .clear        (clear),
    .hold         (hold),
    .gnt          (gnt),
    .ticket       (ticket),
    .ticket_valid (ticket_valid),
    .wrap         (wrap),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    int               win;
    logic [WIDTH-1:0] tk;
    logic             wr;
  } exp_t;

  exp_t             sbq[$];
  int               checks  = 0;
  int               errors  = 0;
  int               cyc     = 0;
  int               m_count = 0;
  int               m_ptr   = N_REQ - 1;
  int               m_win   = 0;
  int               m_phase = 0;
  logic [WIDTH-1:0] m_last  = 4'b0000;

  logic [WIDTH-1:0] exp_seq[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                    4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                    4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                    4'b1010, 4'b1011, 4'b1001, 4'b1000};
  int               exp_order[6] = '{0, 1, 2, 3, 0, 1};
  int               dly[N_REQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input bit flush);
    m_count = 0;
    m_ptr   = N_REQ - 1;
    m_phase = 0;
    m_last  = 4'b0000;
    if (flush) sbq.delete();
  endtask

  // Reference model: tickets are the Gray image of a plain grant count.
  initial forever begin
    int   c;
    int   n;
    exp_t e;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      model_reset(1'b1);
    end else begin
      cyc++;
      if (clear) begin
        model_reset(1'b0);
      end else if (m_phase == 0) begin
        if (req != 4'b0000 && !hold) begin
          m_win = -1;
          for (int k = 1; k <= N_REQ; k++) begin
            c = (m_ptr + k) % N_REQ;
            if (m_win < 0 && ((req >> c) & 4'b0001) != 4'b0000) m_win = c;
          end
          n     = m_count % (1 << WIDTH);
          e.cyc = cyc;
          e.win = m_win;
          e.tk  = WIDTH'(n ^ (n >> 1));
          e.wr  = (n == (1 << WIDTH) - 1);
          sbq.push_back(e);
          m_last  = e.tk;
          m_count = m_count + 1;
          m_ptr   = m_win;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (((req >> m_win) & 4'b0001) == 4'b0000) begin
        m_phase = 0;
      end
    end
  end

  // Monitor: per-cycle invariants plus scoreboard pop on every presented ticket.
  initial forever begin
    exp_t             e;
    logic [N_REQ-1:0] eg;
    @(negedge clk);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("tv_matches_gnt", 32'(ticket_valid), 32'(|gnt));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("ticket_hold", 32'(ticket), 32'(m_last));
    if (ticket_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b ticket=%b, expected no grant (cycle %0d)", gnt, ticket, cyc);
      end else begin
        e  = sbq.pop_front();
        eg = 4'b0001 << e.win;
        chk("grant_cycle", 32'(cyc), 32'(e.cyc));
        chk("grant_gnt", 32'(gnt), 32'(eg));
        chk("grant_ticket", 32'(ticket), 32'(e.tk));
        chk("grant_wrap", 32'(wrap), 32'(e.wr));
      end
    end else begin
      chk("wrap_without_grant", 32'(wrap), 32'd0);
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_grant: got ticket_valid=0, expected gnt to %0d ticket %b (cycle %0d)", sbq[0].win, sbq[0].tk, cyc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic wait_gnt(input string name);
    int cnt;
    cnt = 0;
    while (gnt == 4'b0000 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, 32'(gnt != 4'b0000), 32'd1);
  endtask

  task automatic handshake(input int i, output logic [WIDTH-1:0] t, output logic w,
                           output logic [N_REQ-1:0] g);
    req = req | (4'b0001 << i);
    @(negedge clk);
    wait_gnt("handshake_timeout");
    g   = gnt;
    t   = ticket;
    w   = wrap;
    req = req & ~(4'b0001 << i);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] t;
    logic             w;
    logic [N_REQ-1:0] g;

    // Reset with all requests high, then release with none.
    req = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 32'({gnt, ticket, ticket_valid, wrap, busy}), 32'd0);
    end
    req     = 4'b0000;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_outputs", 32'({gnt, ticket, ticket_valid, wrap, busy}), 32'd0);
    end

    for (int k = 0; k < 8; k++) begin
      handshake(2, t, w, g);
      chk("single_gnt", 32'(g), 32'(4'b0100));
      chk("single_ticket", 32'(t), 32'(exp_seq[k]));
    end

    // Round-robin with every requester active.
    do_clear();
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_gnt("rr_timeout");
      g = gnt;
      chk("rr_order", 32'(g), 32'(4'b0001 << exp_order[k]));
      @(negedge clk) req = req & ~g;
      @(negedge clk) req = req | g;
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    do_clear();
    for (int k = 0; k < 17; k++) begin
      handshake(0, t, w, g);
      chk("wrap_ticket", 32'(t), 32'(exp_seq[k % 16]));
      chk("wrap_flag", 32'(w), 32'(k == 15));
    end

    do_clear();
    hold = 1'b1;
    req  = 4'b0010;
    repeat (5) begin
      @(negedge clk);
      chk("hold_no_gnt", 32'(gnt), 32'd0);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_gnt", 32'(gnt), 32'(4'b0010));
    chk("hold_release_ticket", 32'(ticket), 32'd0);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Clear while the winner is parked in RELEASE with another request pending.
    do_clear();
    handshake(1, t, w, g);
    handshake(1, t, w, g);
    req = 4'b0010;
    @(negedge clk);
    wait_gnt("clear_test_timeout");
    chk("third_ticket", 32'(ticket), 32'(4'b0011));
    req = 4'b0011;
    repeat (4) begin
      @(negedge clk);
      chk("release_stuck_busy", 32'(busy), 32'd1);
    end
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    chk("clear_state", 32'({busy, ticket}), 32'd0);
    @(negedge clk);
    chk("clear_regrant_gnt", 32'(gnt), 32'(4'b0001));
    chk("clear_regrant_ticket", 32'(ticket), 32'd0);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a GRANT cycle.
    req = 4'b1000;
    @(posedge clk);
    #2;
    chk("rst_pre_gnt", 32'(gnt), 32'(4'b1000));
    reset_n = 1'b0;
    #1;
    chk("rst_async_clear", 32'({gnt, ticket_valid, wrap, busy}), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    handshake(2, t, w, g);
    chk("post_reset_ticket", 32'(t), 32'd0);

    // Randomized traffic with hold and occasional clear.
    for (int i = 0; i < N_REQ; i++) dly[i] = -1;
    for (int cy = 0; cy < 3000; cy++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((gnt & (4'b0001 << i)) != 4'b0000) dly[i] = int'($urandom_range(0, 4));
        if (dly[i] >= 0) begin
          if (dly[i] == 0) begin
            req    = req & ~(4'b0001 << i);
            dly[i] = -1;
          end else begin
            dly[i] = dly[i] - 1;
          end
        end else if ((req & (4'b0001 << i)) == 4'b0000 && $urandom_range(0, 99) < 35) begin
          req = req | (4'b0001 << i);
        end
      end
      hold  = ($urandom_range(0, 99) < 15);
      clear = ($urandom_range(0, 299) < 2);
      @(negedge clk);
    end

    req   = 4'b0000;
    hold  = 1'b0;
    clear = 1'b0;
    repeat (6) @(negedge clk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
